// File: rtl/adder_plus_pkg.sv
// Shared types and helpers for the pipelined add/sub datapath.
// Imported by the top and the slice so both agree on widths.
package adder_plus_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic overflow;
    logic zero;
  } flags_t;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_plus_slice.sv
// Combinational ripple segment of full-adder cells.
// c_msb_in exposes the carry into the top bit for signed overflow.
module adder_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c_msb_in
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[SLICE_W];
  assign c_msb_in = c[SLICE_W-1];

endmodule

// File: rtl/pipelined_adder_plus.sv
// Pipelined add/sub: one ripple slice per stage, valid/ready with
// full backpressure; flags are registered alongside the final slice.
module pipelined_adder_plus
  import adder_plus_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of STAGES");
  end

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   adv;

  assign op    = op_e'(in_sub);
  assign b_eff = (op == OP_SUB) ? ~inputB : inputB;

  // adv[k]: stage k may capture this cycle; bubbles collapse
  always_comb begin
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = ~vld[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic                vin;
    logic                cin;
    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic [SW-1:0]       s;
    logic                cout;
    logic                c_msb;
    logic [HI-1:0]       sum_new;
    logic                ld;
    logic                vld_d;
    logic                vld_q;
    logic                carry_d;
    logic                carry_q;
    logic [HI-1:0]       sum_d;
    logic [HI-1:0]       sum_q;

    if (k == 0) begin : g_head
      assign vin     = in_valid;
      assign cin     = in_sub;
      assign a_in    = inputA;
      assign b_in    = b_eff;
      assign sum_new = s;
    end else begin : g_body
      assign vin     = g_st[k-1].vld_q;
      assign cin     = g_st[k-1].carry_q;
      assign a_in    = g_st[k-1].g_op.a_q;
      assign b_in    = g_st[k-1].g_op.b_q;
      assign sum_new = {s, g_st[k-1].sum_q};
    end

    adder_slice #(
      .SLICE_W(SW)
    ) u_slice (
      .a       (a_in[SW-1:0]),
      .b       (b_in[SW-1:0]),
      .cin     (cin),
      .s       (s),
      .cout    (cout),
      .c_msb_in(c_msb)
    );

    // data only moves with a real beat so bubbles never reach Sum
    assign ld = adv[k] & vin;

    always_comb begin
      vld_d   = adv[k] ? vin : vld_q;
      carry_d = ld ? cout : carry_q;
      sum_d   = ld ? sum_new : sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        vld_q   <= vld_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    assign vld[k] = vld_q;

    if (k < STAGES - 1) begin : g_op
      logic [WIDTH-HI-1:0] a_d;
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_d;
      logic [WIDTH-HI-1:0] b_q;

      always_comb begin
        a_d = ld ? a_in[WIDTH-LO-1:SW] : a_q;
        b_d = ld ? b_in[WIDTH-LO-1:SW] : b_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      flags_t flags_d;
      flags_t flags_q;

      always_comb begin
        flags_d = flags_q;
        if (ld) begin
          flags_d.overflow = c_msb ^ cout;
          flags_d.zero     = (sum_new == '0);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign Sum       = g_st[STAGES-1].sum_q;
  assign Carry     = g_st[STAGES-1].carry_q;
  assign Overflow  = g_st[STAGES-1].g_tail.flags_q.overflow;
  assign Zero      = g_st[STAGES-1].g_tail.flags_q.zero;

endmodule

// File: tb/tb_pipelined_adder_plus.sv
// Directed table, backpressure, reset and random scoreboard bench
// for the 32-bit, 4-stage configuration of pipelined_adder_plus.
module tb_pipelined_adder_plus;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic [W-1:0] inputA;
  logic [W-1:0] inputB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Carry;
  logic         Overflow;
  logic         Zero;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    res_t         exp;
  } vec_t;

  vec_t vt[10];
  res_t exp_q[$];
  res_t got;
  res_t mon_e;
  res_t hold_r;
  logic hold_v = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  int   lat, bp_i, guard, seen, out_base;
  logic acc;

  always #5 clk = ~clk;

  pipelined_adder_plus #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sub   (in_sub),
    .inputA   (inputA),
    .inputB   (inputB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (Sum),
    .Carry    (Carry),
    .Overflow (Overflow),
    .Zero     (Zero)
  );

  assign got = {Sum, Carry, Overflow, Zero};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic res_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    res_t         r;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    r.sum = full[W-1:0];
    r.c   = full[W];
    r.v   = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    r.z   = (r.sum == '0);
    return r;
  endfunction

  // scoreboard and stall-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("stall_hold", {out_valid, got}, {1'b1, hold_r});
      hold_v = out_valid && !out_ready;
      hold_r = got;
      if (in_valid && in_ready)
        exp_q.push_back(model(inputA, inputB, in_sub));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("scoreboard", got, mon_e);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    inputA    = '0;
    inputB    = '0;
    out_ready = 1'b1;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 3'b101}};
    vt[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, {32'hFFFF_FFFE, 3'b000}};
    vt[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, {32'h7FFF_FFFF, 3'b110}};
    vt[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 3'b010}};
    vt[4] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, {32'h0100_0100, 3'b000}};
    vt[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, {32'h0000_0000, 3'b101}};
    vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, {32'h0000_0000, 3'b001}};
    vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 3'b111}};
    vt[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, {32'hFFFF_FFFF, 3'b000}};
    vt[9] = '{32'hDEAD_BEEF, 32'h0101_0101, 1'b0, {32'hDFAE_BFF0, 3'b000}};

    #1;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_result", got, 64'd0);
    chk("rst_in_ready", in_ready, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single beats: latency and hand-computed results
    for (int i = 0; i < 10; i++) begin
      inputA   = vt[i].a;
      inputB   = vt[i].b;
      in_sub   = vt[i].sub;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("latency%0d", i), lat, S);
      chk($sformatf("vec%0d", i), got, vt[i].exp);
    end
    @(posedge clk); #1;

    // back-to-back mixed add/sub at full rate
    out_base = n_out;
    for (int i = 0; i < 10; i++) begin
      inputA   = vt[i].a;
      inputB   = vt[i].b;
      in_sub   = vt[i].sub;
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("tput_ready%0d", i), in_ready, 64'd1);
      @(posedge clk); #1;
    end
    drain();
    chk("tput_count", n_out - out_base, 64'd10);

    // backpressure: 10 beats, consumer stalled for 6 cycles
    out_base  = n_out;
    out_ready = 1'b0;
    bp_i      = 0;
    for (int c = 0; c < 6; c++) begin
      inputA   = 32'h1000_0000 + bp_i;
      inputB   = bp_i * 3;
      in_sub   = bp_i[0];
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) bp_i++;
    end
    chk("bp_accepted", bp_i, 64'd4);
    chk("bp_in_ready", in_ready, 64'd0);
    chk("bp_out_valid", out_valid, 64'd1);
    out_ready = 1'b1;
    guard     = 0;
    while (bp_i < 10 && guard < 40) begin
      inputA   = 32'h1000_0000 + bp_i;
      inputB   = bp_i * 3;
      in_sub   = bp_i[0];
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) bp_i++;
      guard++;
    end
    chk("bp_all_in", bp_i, 64'd10);
    drain();
    chk("bp_count", n_out - out_base, 64'd10);

    // reset with beats in flight and a result at the output
    for (int i = 0; i < 4; i++) begin
      inputA   = vt[i].a;
      inputB   = vt[i].b;
      in_sub   = vt[i].sub;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 64'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", out_valid, 64'd0);
    chk("mid_rst_result", got, 64'd0);
    chk("mid_rst_in_ready", in_ready, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_rst_quiet", seen, 64'd0);

    // random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      inputA    = $urandom;
      inputB    = $urandom;
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0) inputA = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) inputB = 32'h8000_0000;
      @(posedge clk); #1;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
